// File: rtl/riscv_pkg.sv
// Shared memory-access definitions for the pipeline and its data memory.
package riscv_pkg;

  // Default data memory size in bytes.
  parameter int unsigned DMEM_SIZE = 1024;

  // Access size/extension; values follow the RV32 load funct3 encoding.
  typedef enum logic [2:0] {
    MEM_BYTE   = 3'd0,
    MEM_HALF   = 3'd1,
    MEM_WORD   = 3'd2,
    MEM_BYTE_U = 3'd4,
    MEM_HALF_U = 3'd5
  } mem_op_e;

endpackage

// File: rtl/dmem_pipe.sv
// Byte-addressable little-endian data memory behind a valid/ready handshake with a configurable
// response latency. One request is outstanding at a time; errors suppress the access.
module dmem_pipe
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_BYTES = DMEM_SIZE,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  mem_op_e         req_op_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam logic [3:0] WaitInit = 4'(RD_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [7:0]        mem [DEPTH_BYTES];

  logic              accept;
  logic              size_half, size_word;
  logic [1:0]        last_off;
  logic              misaligned, out_of_range, req_err;
  logic [XLEN:0]     end_addr;
  logic [AW-1:0]     idx0, idx1, idx2, idx3;
  logic [7:0]        b0, b1, b2, b3;
  logic [XLEN-1:0]   load_data;

  assign accept      = (state_q == StIdle) && req_valid_i;
  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  // Decode access size; _U ops share the size of their signed counterpart, also for stores.
  always_comb begin
    size_half = 1'b0;
    size_word = 1'b0;
    unique case (req_op_i)
      MEM_HALF, MEM_HALF_U: size_half = 1'b1;
      MEM_WORD:             size_word = 1'b1;
      default:              ;
    endcase
  end

  // Alignment and range checks; the extra address bit keeps the last-byte sum from wrapping.
  always_comb begin
    last_off     = size_word ? 2'd3 : (size_half ? 2'd1 : 2'd0);
    misaligned   = (size_half & req_addr_i[0]) | (size_word & (|req_addr_i[1:0]));
    end_addr     = {1'b0, req_addr_i} + (XLEN+1)'(last_off);
    out_of_range = end_addr >= (XLEN+1)'(DEPTH_BYTES);
    req_err      = misaligned | out_of_range;
  end

  // Byte lanes of the addressed location; upper lanes may wrap on errored requests but are unused.
  always_comb begin
    idx0 = req_addr_i[AW-1:0];
    idx1 = idx0 + AW'(1);
    idx2 = idx0 + AW'(2);
    idx3 = idx0 + AW'(3);
    b0   = mem[idx0];
    b1   = mem[idx1];
    b2   = mem[idx2];
    b3   = mem[idx3];
  end

  // Load extension by op.
  always_comb begin
    load_data = '0;
    unique case (req_op_i)
      MEM_BYTE:   load_data = {{(XLEN-8){b0[7]}}, b0};
      MEM_BYTE_U: load_data = XLEN'(b0);
      MEM_HALF:   load_data = {{(XLEN-16){b1[7]}}, b1, b0};
      MEM_HALF_U: load_data = XLEN'({b1, b0});
      MEM_WORD:   load_data = XLEN'({b3, b2, b1, b0});
      default:    load_data = '0;
    endcase
  end

  // Storage commit at the accept edge; storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (accept && req_we_i && !req_err) begin
      mem[idx0] <= req_wdata_i[7:0];
      if (size_half || size_word) begin
        mem[idx1] <= req_wdata_i[15:8];
      end
      if (size_word) begin
        mem[idx2] <= req_wdata_i[23:16];
        mem[idx3] <= req_wdata_i[31:24];
      end
    end
  end

  // Next-state, latency counter and response capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          err_d   = req_err;
          rdata_d = (req_err || req_we_i) ? '0 : load_data;
          if (RD_LATENCY == 1) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; reset drops any in-flight response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_pipe.sv
// Directed bench for dmem_pipe: one instance at latency 3 for functional checks, one at
// latency 4 for the reset-during-wait scenario.
module tb_dmem_pipe;
  import riscv_pkg::*;

  localparam int unsigned Depth = DMEM_SIZE;

  logic        clk;
  logic        rst_n;
  logic        req_valid_a, req_valid_b;
  logic        req_we;
  logic [31:0] req_addr, req_wdata;
  mem_op_e     req_op;
  logic        rsp_ready;

  logic        req_ready_a, rsp_valid_a, rsp_err_a;
  logic [31:0] rsp_rdata_a;
  logic        req_ready_b, rsp_valid_b, rsp_err_b;
  logic [31:0] rsp_rdata_b;

  int n_tests = 0;
  int n_fail  = 0;
  int sel     = 0;

  logic        rv_s, rr_s, re_s;
  logic [31:0] rd_s;

  always_comb begin
    rv_s = (sel == 0) ? rsp_valid_a : rsp_valid_b;
    rr_s = (sel == 0) ? req_ready_a : req_ready_b;
    re_s = (sel == 0) ? rsp_err_a   : rsp_err_b;
    rd_s = (sel == 0) ? rsp_rdata_a : rsp_rdata_b;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_pipe #(.XLEN(32), .DEPTH_BYTES(Depth), .RD_LATENCY(3)) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid_a),
    .req_ready_o (req_ready_a),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_op_i    (req_op),
    .rsp_valid_o (rsp_valid_a),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata_a),
    .rsp_err_o   (rsp_err_a)
  );

  dmem_pipe #(.XLEN(32), .DEPTH_BYTES(Depth), .RD_LATENCY(4)) u_dut4 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid_b),
    .req_ready_o (req_ready_b),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_op_i    (req_op),
    .rsp_valid_o (rsp_valid_b),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata_b),
    .rsp_err_o   (rsp_err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE with rsp_ready held high; returns response and latency.
  task automatic xfer(input int which, input logic we, input mem_op_e op,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int lat);
    sel       = which;
    rsp_ready = 1'b1;
    req_we    = we;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    if (which == 0) req_valid_a = 1'b1;
    else            req_valid_b = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    lat = 1;
    while (!rv_s && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = rd_s;
    err   = re_s;
    if (rv_s) begin
      @(posedge clk); #1;
    end else begin
      check("rsp_timeout", {31'd0, rv_s}, 32'd1);
    end
  endtask

  logic [31:0] rdata;
  logic        err;
  int          lat;

  initial begin
    rst_n       = 1'b0;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    req_we      = 1'b0;
    req_op      = MEM_WORD;
    req_addr    = '0;
    req_wdata   = '0;
    rsp_ready   = 1'b1;

    #3;
    check("rst_req_ready", {31'd0, req_ready_a}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata_a, 32'd0);
    check("rst_rsp_err",   {31'd0, rsp_err_a}, 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Store then load a word, with latency measured on both.
    xfer(0, 1'b1, MEM_WORD, 32'h00, 32'h1234_5678, rdata, err, lat);
    check("sw_lat", lat, 32'd3);
    check("sw_rdata", rdata, 32'd0);
    check("sw_err", {31'd0, err}, 32'd0);
    xfer(0, 1'b0, MEM_WORD, 32'h00, 32'h0, rdata, err, lat);
    check("lw_lat", lat, 32'd3);
    check("lw_rdata", rdata, 32'h1234_5678);
    check("lw_err", {31'd0, err}, 32'd0);

    // Byte extension: mem[4]=0x80, mem[5]=0x55, mem[6]=0x66, mem[7]=0x77.
    xfer(0, 1'b1, MEM_WORD, 32'h04, 32'h7766_5580, rdata, err, lat);
    xfer(0, 1'b0, MEM_BYTE, 32'h04, 32'h0, rdata, err, lat);
    check("lb_80", rdata, 32'hFFFF_FF80);
    xfer(0, 1'b0, MEM_BYTE_U, 32'h04, 32'h0, rdata, err, lat);
    check("lbu_80", rdata, 32'h0000_0080);

    // Byte store into a cleared word uses only wdata[7:0].
    xfer(0, 1'b1, MEM_WORD, 32'h10, 32'h0, rdata, err, lat);
    xfer(0, 1'b1, MEM_BYTE, 32'h11, 32'hFFFF_FFA5, rdata, err, lat);
    xfer(0, 1'b0, MEM_WORD, 32'h10, 32'h0, rdata, err, lat);
    check("sb_lw", rdata, 32'h0000_A500);

    // Halfword store and loads.
    xfer(0, 1'b1, MEM_WORD, 32'h20, 32'h0, rdata, err, lat);
    xfer(0, 1'b1, MEM_HALF, 32'h22, 32'h1234_ABCD, rdata, err, lat);
    xfer(0, 1'b0, MEM_HALF_U, 32'h22, 32'h0, rdata, err, lat);
    check("lhu", rdata, 32'h0000_ABCD);
    xfer(0, 1'b0, MEM_HALF, 32'h22, 32'h0, rdata, err, lat);
    check("lh", rdata, 32'hFFFF_ABCD);
    xfer(0, 1'b0, MEM_BYTE_U, 32'h23, 32'h0, rdata, err, lat);
    check("lbu_23", rdata, 32'h0000_00AB);
    xfer(0, 1'b0, MEM_WORD, 32'h20, 32'h0, rdata, err, lat);
    check("sh_lw", rdata, 32'hABCD_0000);

    // Store with an unsigned op behaves as the signed size.
    xfer(0, 1'b1, MEM_WORD, 32'h30, 32'h0, rdata, err, lat);
    xfer(0, 1'b1, MEM_BYTE_U, 32'h30, 32'h1234_565A, rdata, err, lat);
    xfer(0, 1'b0, MEM_WORD, 32'h30, 32'h0, rdata, err, lat);
    check("sbu_lw", rdata, 32'h0000_005A);

    // Errors.
    xfer(0, 1'b0, MEM_WORD, 32'h02, 32'h0, rdata, err, lat);
    check("lw_mis_err", {31'd0, err}, 32'd1);
    check("lw_mis_rdata", rdata, 32'd0);
    xfer(0, 1'b1, MEM_HALF, 32'h05, 32'hFFFF_FFFF, rdata, err, lat);
    check("sh_mis_err", {31'd0, err}, 32'd1);
    xfer(0, 1'b0, MEM_WORD, 32'h04, 32'h0, rdata, err, lat);
    check("sh_mis_nowrite", rdata, 32'h7766_5580);
    xfer(0, 1'b0, MEM_WORD, Depth - 2, 32'h0, rdata, err, lat);
    check("lw_top_err", {31'd0, err}, 32'd1);
    xfer(0, 1'b1, MEM_BYTE, Depth, 32'h11, rdata, err, lat);
    check("sb_oor_err", {31'd0, err}, 32'd1);
    xfer(0, 1'b1, MEM_HALF, Depth - 2, 32'h0000_BEEF, rdata, err, lat);
    check("sh_top_err", {31'd0, err}, 32'd0);
    xfer(0, 1'b0, MEM_HALF_U, Depth - 2, 32'h0, rdata, err, lat);
    check("lhu_top", rdata, 32'h0000_BEEF);
    check("lhu_top_err", {31'd0, err}, 32'd0);
    xfer(0, 1'b0, MEM_BYTE_U, Depth - 1, 32'h0, rdata, err, lat);
    check("lbu_last", rdata, 32'h0000_00BE);
    xfer(0, 1'b0, MEM_WORD, 32'hFFFF_FFFC, 32'h0, rdata, err, lat);
    check("lw_wrap_err", {31'd0, err}, 32'd1);

    // Backpressure: response held stable while rsp_ready is low.
    sel         = 0;
    rsp_ready   = 1'b0;
    req_we      = 1'b0;
    req_op      = MEM_WORD;
    req_addr    = 32'h00;
    req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    req_addr    = 32'h04;
    for (int i = 0; i < 10 && !rsp_valid_a; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, rsp_valid_a}, 32'd1);
      check("bp_rdata", rsp_rdata_a, 32'h1234_5678);
      check("bp_err",   {31'd0, rsp_err_a}, 32'd0);
      check("bp_ready", {31'd0, req_ready_a}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rel_valid", {31'd0, rsp_valid_a}, 32'd0);
    check("bp_rel_ready", {31'd0, req_ready_a}, 32'd1);

    // Reset while a store waits out its latency.
    sel         = 1;
    req_we      = 1'b1;
    req_op      = MEM_WORD;
    req_addr    = 32'h08;
    req_wdata   = 32'hDEAD_BEEF;
    req_valid_b = 1'b1;
    @(posedge clk); #1;
    req_valid_b = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("wait_ready", {31'd0, req_ready_b}, 32'd0);
    check("wait_valid", {31'd0, rsp_valid_b}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, rsp_valid_b}, 32'd0);
    check("midrst_ready", {31'd0, req_ready_b}, 32'd1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1, 1'b0, MEM_WORD, 32'h08, 32'h0, rdata, err, lat);
    check("midrst_lw", rdata, 32'hDEAD_BEEF);
    check("lat4", lat, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
